// File: rtl/secure_door_ctrl_if.sv
// Keypad/door signal bundle for secure_door_ctrl.
// The keypad side is the master and the controller is the slave.
interface secure_door_ctrl_if #(
  parameter int DIGIT_W      = 4,
  parameter int MAX_ATTEMPTS = 3
);
  localparam int ATT_W = $clog2(MAX_ATTEMPTS + 1);

  logic [DIGIT_W-1:0] digit_in;
  logic               digit_valid;
  logic               enter;
  logic               door_lock;
  logic               alarm;
  logic [ATT_W-1:0]   attempt_count;
  logic [1:0]         state;

  modport master (
    output digit_in, digit_valid, enter,
    input  door_lock, alarm, attempt_count, state
  );

  modport slave (
    input  digit_in, digit_valid, enter,
    output door_lock, alarm, attempt_count, state
  );
endinterface

// File: rtl/secure_door_ctrl.sv
// Keypad door lock: passcode entry, timed unlock, and a wrong-attempt alarm lockout.
// Optional feature macro PASSCODE_CHANGE_EN: the code can be rewritten while unlocked.
module secure_door_ctrl #(
  parameter int                          DIGIT_W        = 4,
  parameter int                          NUM_DIGITS     = 4,
  parameter logic [DIGIT_W*NUM_DIGITS-1:0] PASSCODE     = 16'hA5C3,
  parameter int                          MAX_ATTEMPTS   = 3,
  parameter int                          UNLOCK_CYCLES  = 50,
  parameter int                          LOCKOUT_CYCLES = 100
) (
  input logic               clock,
  input logic               clear,
  secure_door_ctrl_if.slave bus
);

  localparam int BUF_W   = DIGIT_W * NUM_DIGITS;
  localparam int CNT_W   = $clog2(NUM_DIGITS + 1);
  localparam int ATT_W   = $clog2(MAX_ATTEMPTS + 1);
  localparam int MAX_CYC = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TMR_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_UNLOCKED = 2'd1,
    ST_LOCKOUT  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ATT_W-1:0]   att_q, att_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               lock_q, lock_d;
  logic               alarm_q, alarm_d;
  logic [BUF_W-1:0]   code_s;
  logic [BUF_W+DIGIT_W-1:0] wide_s;
  logic [BUF_W-1:0]   shifted_s;
  logic [CNT_W-1:0]   cnt_inc_s;
  logic               full_s;

`ifdef PASSCODE_CHANGE_EN
  logic [BUF_W-1:0]   code_q, code_d;
  assign code_s = code_q;
`else
  assign code_s = PASSCODE;
`endif

  // New digit enters LSB-side; the oldest digit falls off the top.
  assign wide_s    = {buf_q, bus.digit_in};
  assign shifted_s = wide_s[BUF_W-1:0];
  assign full_s    = (cnt_q == CNT_W'(NUM_DIGITS));
  assign cnt_inc_s = full_s ? cnt_q : cnt_q + CNT_W'(1);

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    att_d   = att_q;
    tmr_d   = tmr_q;
    lock_d  = lock_q;
    alarm_d = alarm_q;
`ifdef PASSCODE_CHANGE_EN
    code_d  = code_q;
`endif
    case (state_q)
      ST_LOCKED: begin
        if (bus.enter) begin
          buf_d = {BUF_W{1'b0}};
          cnt_d = {CNT_W{1'b0}};
          if (full_s && (buf_q == code_s)) begin
            state_d = ST_UNLOCKED;
            lock_d  = 1'b0;
            att_d   = {ATT_W{1'b0}};
            tmr_d   = TMR_W'(UNLOCK_CYCLES - 1);
          end else if (att_q == ATT_W'(MAX_ATTEMPTS - 1)) begin
            state_d = ST_LOCKOUT;
            alarm_d = 1'b1;
            att_d   = ATT_W'(MAX_ATTEMPTS);
            tmr_d   = TMR_W'(LOCKOUT_CYCLES - 1);
          end else begin
            att_d = att_q + ATT_W'(1);
          end
        end else if (bus.digit_valid) begin
          buf_d = shifted_s;
          cnt_d = cnt_inc_s;
        end else begin
          buf_d = buf_q;
        end
      end
      ST_UNLOCKED: begin
        if (tmr_q == TMR_W'(0)) begin
          state_d = ST_LOCKED;
          lock_d  = 1'b1;
          buf_d   = {BUF_W{1'b0}};
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
`ifdef PASSCODE_CHANGE_EN
        // A full entry rewrites the code and restarts the open window.
        if (bus.enter) begin
          buf_d = {BUF_W{1'b0}};
          cnt_d = {CNT_W{1'b0}};
          if (full_s) begin
            code_d  = buf_q;
            tmr_d   = TMR_W'(UNLOCK_CYCLES - 1);
            state_d = ST_UNLOCKED;
            lock_d  = 1'b0;
          end else begin
            code_d = code_q;
          end
        end else if (bus.digit_valid && (tmr_q != TMR_W'(0))) begin
          buf_d = shifted_s;
          cnt_d = cnt_inc_s;
        end else begin
          code_d = code_q;
        end
`endif
      end
      ST_LOCKOUT: begin
        if (tmr_q == TMR_W'(0)) begin
          state_d = ST_LOCKED;
          alarm_d = 1'b0;
          att_d   = {ATT_W{1'b0}};
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      default: begin
        state_d = ST_LOCKED;
        lock_d  = 1'b1;
        alarm_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous clear.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= ST_LOCKED;
      buf_q   <= {BUF_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      att_q   <= {ATT_W{1'b0}};
      tmr_q   <= {TMR_W{1'b0}};
      lock_q  <= 1'b1;
      alarm_q <= 1'b0;
`ifdef PASSCODE_CHANGE_EN
      code_q  <= PASSCODE;
`endif
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      att_q   <= att_d;
      tmr_q   <= tmr_d;
      lock_q  <= lock_d;
      alarm_q <= alarm_d;
`ifdef PASSCODE_CHANGE_EN
      code_q  <= code_d;
`endif
    end
  end

  assign bus.door_lock     = lock_q;
  assign bus.alarm         = alarm_q;
  assign bus.attempt_count = att_q;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_secure_door_ctrl.sv
// Scoreboard bench for secure_door_ctrl with default parameters.
// Expected outputs are queued as stimulus is driven and compared after the edge.
module tb_secure_door_ctrl;

  logic clock = 1'b0;
  logic clear = 1'b1;

  secure_door_ctrl_if #(.DIGIT_W(4), .MAX_ATTEMPTS(3)) bus();

  secure_door_ctrl dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       lock;
    logic       alarm;
    logic [1:0] att;
    logic [1:0] st;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks_n = 0;
  int    errors_n = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_n++;
    if (obs !== exp) begin
      errors_n++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic lock, input logic alarm,
                          input logic [1:0] att, input logic [1:0] st);
    exp_t e;
    e.lock  = lock;
    e.alarm = alarm;
    e.att   = att;
    e.st    = st;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic pop_cmp();
    exp_t  e;
    string t;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check({t, ".door_lock"}, {31'd0, bus.door_lock}, {31'd0, e.lock});
      check({t, ".alarm"}, {31'd0, bus.alarm}, {31'd0, e.alarm});
      check({t, ".attempt_count"}, {30'd0, bus.attempt_count}, {30'd0, e.att});
      check({t, ".state"}, {30'd0, bus.state}, {30'd0, e.st});
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic key(input logic [3:0] d);
    bus.digit_in    = d;
    bus.digit_valid = 1'b1;
    @(negedge clock);
    bus.digit_valid = 1'b0;
  endtask

  task automatic press_enter(input logic with_digit, input logic [3:0] d);
    bus.digit_in    = d;
    bus.digit_valid = with_digit;
    bus.enter       = 1'b1;
    @(negedge clock);
    bus.enter       = 1'b0;
    bus.digit_valid = 1'b0;
  endtask

  // Four digits followed by a separate enter strobe.
  task automatic code4(input logic [15:0] c);
    key(c[15:12]);
    key(c[11:8]);
    key(c[7:4]);
    key(c[3:0]);
    press_enter(1'b0, 4'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.digit_in    = 4'd0;
    bus.digit_valid = 1'b0;
    bus.enter       = 1'b0;
    clear           = 1'b1;
    wait_edges(2);
    push_exp("reset", 1'b1, 1'b0, 2'd0, 2'd0);
    pop_cmp();
    clear = 1'b0;

    // Correct code opens the door for exactly 50 clocks.
    push_exp("unlock_ok", 1'b0, 1'b0, 2'd0, 2'd1);
    code4(16'hA5C3);
    pop_cmp();
    push_exp("unlock_last_cycle", 1'b0, 1'b0, 2'd0, 2'd1);
    wait_edges(49);
    pop_cmp();
    push_exp("relock", 1'b1, 1'b0, 2'd0, 2'd0);
    wait_edges(1);
    pop_cmp();

    // Three wrong entries trigger lockout.
    push_exp("wrong1", 1'b1, 1'b0, 2'd1, 2'd0);
    code4(16'h1234);
    pop_cmp();
    push_exp("wrong2", 1'b1, 1'b0, 2'd2, 2'd0);
    code4(16'h1234);
    pop_cmp();
    push_exp("lockout", 1'b1, 1'b1, 2'd3, 2'd2);
    code4(16'h1234);
    pop_cmp();
    push_exp("lockout_ignores_code", 1'b1, 1'b1, 2'd3, 2'd2);
    code4(16'hA5C3);
    pop_cmp();
    push_exp("lockout_last_cycle", 1'b1, 1'b1, 2'd3, 2'd2);
    wait_edges(94);
    pop_cmp();
    push_exp("lockout_exit", 1'b1, 1'b0, 2'd0, 2'd0);
    wait_edges(1);
    pop_cmp();

    // Oldest of five digits is dropped.
    push_exp("five_digits_unlock", 1'b0, 1'b0, 2'd0, 2'd1);
    key(4'h7);
    code4(16'hA5C3);
    pop_cmp();
    wait_edges(50);
    push_exp("short_entry", 1'b1, 1'b0, 2'd1, 2'd0);
    key(4'hA);
    key(4'h5);
    key(4'hC);
    press_enter(1'b0, 4'd0);
    pop_cmp();

    // Enter beats a simultaneous digit: only three digits were buffered.
    push_exp("enter_wins", 1'b1, 1'b0, 2'd2, 2'd0);
    key(4'hA);
    key(4'h5);
    key(4'hC);
    press_enter(1'b1, 4'h3);
    pop_cmp();
    push_exp("unlock_clears_attempts", 1'b0, 1'b0, 2'd0, 2'd1);
    code4(16'hA5C3);
    pop_cmp();

    // Clear aborts unlock mid-timer.
    wait_edges(5);
    clear = 1'b1;
    push_exp("clear_mid_unlock", 1'b1, 1'b0, 2'd0, 2'd0);
    wait_edges(1);
    clear = 1'b0;
    pop_cmp();

    // Clear aborts lockout mid-timer.
    code4(16'h1111);
    code4(16'h2222);
    push_exp("lockout_again", 1'b1, 1'b1, 2'd3, 2'd2);
    code4(16'h3333);
    pop_cmp();
    wait_edges(10);
    clear = 1'b1;
    push_exp("clear_mid_lockout", 1'b1, 1'b0, 2'd0, 2'd0);
    wait_edges(1);
    clear = 1'b0;
    pop_cmp();

`ifdef PASSCODE_CHANGE_EN
    push_exp("chg_unlock", 1'b0, 1'b0, 2'd0, 2'd1);
    code4(16'hA5C3);
    pop_cmp();
    push_exp("chg_reload", 1'b0, 1'b0, 2'd0, 2'd1);
    code4(16'h1234);
    pop_cmp();
    push_exp("chg_reload_last_cycle", 1'b0, 1'b0, 2'd0, 2'd1);
    wait_edges(49);
    pop_cmp();
    push_exp("chg_relock", 1'b1, 1'b0, 2'd0, 2'd0);
    wait_edges(1);
    pop_cmp();
    push_exp("chg_old_code_fails", 1'b1, 1'b0, 2'd1, 2'd0);
    code4(16'hA5C3);
    pop_cmp();
    push_exp("chg_new_code_unlocks", 1'b0, 1'b0, 2'd0, 2'd1);
    code4(16'h1234);
    pop_cmp();
`else
    push_exp("fixed_unlock", 1'b0, 1'b0, 2'd0, 2'd1);
    code4(16'hA5C3);
    pop_cmp();
    push_exp("fixed_ignores_entry", 1'b0, 1'b0, 2'd0, 2'd1);
    code4(16'h1234);
    pop_cmp();
    push_exp("fixed_last_cycle", 1'b0, 1'b0, 2'd0, 2'd1);
    wait_edges(44);
    pop_cmp();
    push_exp("fixed_relock", 1'b1, 1'b0, 2'd0, 2'd0);
    wait_edges(1);
    pop_cmp();
    push_exp("fixed_code_kept", 1'b0, 1'b0, 2'd0, 2'd1);
    code4(16'hA5C3);
    pop_cmp();
`endif

    $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
    $finish;
  end

endmodule

// File: doc/secure_door_ctrl.md
SECURE_DOOR_CTRL -- requirements
Module: secure_door_ctrl

Interface
- REQ-001: Parameter DIGIT_W, default 4, SHALL set the bit width of one keypad digit.
- REQ-002: Parameter NUM_DIGITS, default 4, SHALL set the number of digits in a passcode.
- REQ-003: Parameter PASSCODE, default 16'hA5C3 (width DIGIT_W*NUM_DIGITS), SHALL set the reset passcode; the first digit entered maps to the most significant digit.
- REQ-004: Parameter MAX_ATTEMPTS, default 3, SHALL set the number of wrong attempts that trigger lockout.
- REQ-005: Parameter UNLOCK_CYCLES, default 50, SHALL set the unlock hold time in clocks.
- REQ-006: Parameter LOCKOUT_CYCLES, default 100, SHALL set the alarm/lockout time in clocks.
- REQ-007: clock  input  1  SHALL be the single rising-edge clock.
- REQ-008: clear  input  1  SHALL be the synchronous, active-high reset.
- REQ-009: digit_in  input  DIGIT_W  SHALL carry a keypad digit, qualified by digit_valid.
- REQ-010: digit_valid  input  1  SHALL be a one-cycle strobe for digit_in.
- REQ-011: enter  input  1  SHALL be a one-cycle strobe that submits the buffered digits.
- REQ-012: door_lock  output  1  SHALL read 1 = locked, 0 = open.
- REQ-013: alarm  output  1  SHALL read 1 while in lockout.
- REQ-014: attempt_count  output  $clog2(MAX_ATTEMPTS+1)  SHALL show the consecutive wrong attempts.
- REQ-015: state  output  2  SHALL encode the FSM state: LOCKED=0, UNLOCKED=1, LOCKOUT=2.

Function
- REQ-016: All outputs SHALL be registered; the effect of an input sampled at edge N SHALL be visible after edge N.
- REQ-017: In LOCKED, each digit_valid SHALL shift digit_in into the buffer LSB-side, and the digit count SHALL saturate at NUM_DIGITS.
- REQ-018: Digits beyond NUM_DIGITS SHALL drop the oldest digit; the last NUM_DIGITS digits are compared.
- REQ-019: On enter in LOCKED with count == NUM_DIGITS and buffer == stored code, the block SHALL go to UNLOCKED, set door_lock=0, and clear attempt_count.
- REQ-020: Any other enter in LOCKED (short entry or mismatch) SHALL increment attempt_count.
- REQ-021: When the increment reaches MAX_ATTEMPTS, the block SHALL instead go to LOCKOUT with alarm=1, and attempt_count SHALL hold at MAX_ATTEMPTS.
- REQ-022: Every enter SHALL clear the buffer and the digit count.
- REQ-023: When enter and digit_valid are asserted in the same cycle, enter SHALL win and the digit SHALL be discarded.
- REQ-024: UNLOCKED SHALL last exactly UNLOCK_CYCLES clocks, then the block SHALL return to LOCKED with door_lock=1.
- REQ-025: LOCKOUT SHALL ignore digit_valid and enter for exactly LOCKOUT_CYCLES clocks, then go to LOCKED with alarm=0 and attempt_count=0.
- REQ-026: The timer SHALL be one down-counter sized for max(UNLOCK_CYCLES, LOCKOUT_CYCLES), loaded on state entry; the transition SHALL occur when it reaches 0.
- REQ-027: A correct entry SHALL only clear attempt_count when the block is not in LOCKOUT.

Reset
- REQ-028: While clear=1 at a rising edge, the block SHALL set state=LOCKED, door_lock=1, alarm=0, attempt_count=0, buffer=0, count=0, timer=0, and stored code=PASSCODE.
- REQ-029: clear SHALL override all inputs and SHALL abort UNLOCKED or LOCKOUT mid-timer.

Configuration
- REQ-030: With PASSCODE_CHANGE_EN defined, UNLOCKED SHALL accept digits per REQ-017/018, and enter with count == NUM_DIGITS SHALL load the buffer into the stored code and reload the unlock timer.
- REQ-031: With PASSCODE_CHANGE_EN defined, an enter in UNLOCKED with count < NUM_DIGITS SHALL clear the buffer and leave the stored code unchanged.
- REQ-032: Without PASSCODE_CHANGE_EN, UNLOCKED SHALL ignore digit_valid and enter, and the stored code SHALL remain PASSCODE.

Verification
- REQ-033: Defaults; enter digits A,5,C,3 then enter -> door_lock=0 next cycle, attempt_count=0; door_lock=1 again after 50 clocks.
- REQ-034: Three entries of 1,2,3,4 plus enter -> attempt_count goes 1,2, then state=LOCKOUT, alarm=1; correct code during lockout is ignored; alarm=0 and attempt_count=0 after 100 clocks.
- REQ-035: Digits 7,A,5,C,3 then enter -> unlock (oldest digit dropped); digits A,5,C then enter -> attempt_count=1 (short entry).
- REQ-036: enter asserted with digit_valid on the 4th digit -> digit discarded, attempt_count=1, door_lock stays 1.
- REQ-037: clear=1 mid-UNLOCKED and mid-LOCKOUT -> next cycle door_lock=1, alarm=0, state=LOCKED.
- REQ-038: PASSCODE_CHANGE_EN defined; unlock, enter 1,2,3,4 plus enter, wait for relock -> A,5,C,3 fails and 1,2,3,4 unlocks; without the macro, A,5,C,3 still unlocks.
